// File: rtl/calc.sv
// Address-width helpers shared by the framebuffer command handlers.
// Every width is at least one bit so degenerate panels still elaborate.
package calc;

    function automatic int num_row_address_bits(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int num_column_address_bits(input int columns);
        return (columns > 1) ? $clog2(columns) : 1;
    endfunction

    function automatic int num_pixelcolorselect_bits(input int bytes_per_pixel);
        return (bytes_per_pixel > 1) ? $clog2(bytes_per_pixel) : 1;
    endfunction

endpackage

// File: rtl/readrect_pkg.sv
// Shared types and constants for the readrect command handler.
package readrect_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARGS,
        S_CLIP,
        S_READ,
        S_DRAIN,
        S_DONE
    } readrect_state_t;

    localparam int READRECT_NUM_ARGS   = 4;
    localparam int READRECT_FIFO_DEPTH = 2;

endpackage

// File: rtl/readrect_skid_fifo.sv
// 2-entry byte FIFO with fall-through: a push into an empty FIFO is visible
// on head in the same cycle and can be popped without being stored.
module readrect_skid_fifo
    import readrect_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       valid,
    output logic [1:0] count
);

    logic [7:0] mem [READRECT_FIFO_DEPTH];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       empty;
    logic       take;
    logic       store;
    logic       drop;

    always_comb begin
        empty = (count == 2'd0);
        valid = !empty || push;
        head  = !empty ? mem[rd_ptr] : (push ? push_data : 8'h00);
        take  = valid && pop;
        store = push && !(empty && take);
        drop  = take && !empty;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            count <= count + 2'(store) - 2'(drop);
            if (store) wr_ptr <= ~wr_ptr;
            if (drop)  rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/control_cmd_readrect.sv
// Reads a clipped rectangle out of the framebuffer and streams it as bytes.
// Define READRECT_HEADER_EN to prefix the stream with a 16-bit big-endian byte count.
module control_cmd_readrect
    import readrect_pkg::*;
#(
    parameter int BYTES_PER_PIXEL = 2,
    parameter int PIXEL_HEIGHT    = 16,
    parameter int PIXEL_WIDTH     = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic [7:0] data_in,
    output logic ready_for_data,
    output logic [calc::num_row_address_bits(PIXEL_HEIGHT)-1:0] row,
    output logic [calc::num_column_address_bits(PIXEL_WIDTH)-1:0] column,
    output logic [calc::num_pixelcolorselect_bits(BYTES_PER_PIXEL)-1:0] pixel,
    output logic ram_read_enable,
    output logic ram_access_start,
    input  logic [7:0] ram_data_in,
    output logic [7:0] tx_data,
    output logic tx_valid,
    input  logic tx_ready,
    output logic done
);

    localparam int ROW_W = calc::num_row_address_bits(PIXEL_HEIGHT);
    localparam int COL_W = calc::num_column_address_bits(PIXEL_WIDTH);
    localparam int PIX_W = calc::num_pixelcolorselect_bits(BYTES_PER_PIXEL);
`ifdef READRECT_HEADER_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif

    readrect_state_t state, state_nx;

    logic [1:0]       arg_idx;
    logic [7:0]       arg_x, arg_y, arg_w, arg_h;
    logic [COL_W-1:0] col_first, col_last, col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic [15:0]      byte_total;
    logic [16:0]      items_left;
    logic [1:0]       hdr_left;
    logic             inflight, inflight_hdr, first_rd;
    logic [7:0]       hdr_byte;

    logic [8:0]  x9, y9, w_room, h_room, w_eff, h_eff;
    logic        zero_area;
    logic [15:0] clip_bytes;
    logic [1:0]  fifo_count;
    logic [2:0]  occ;
    logic        issue, hdr_issue, rd_issue, abort, drained, push;
    logic [7:0]  push_data;

    always_comb begin
        x9         = {1'b0, arg_x};
        y9         = {1'b0, arg_y};
        w_room     = 9'(PIXEL_WIDTH) - x9;
        h_room     = 9'(PIXEL_HEIGHT) - y9;
        w_eff      = ({1'b0, arg_w} < w_room) ? {1'b0, arg_w} : w_room;
        h_eff      = ({1'b0, arg_h} < h_room) ? {1'b0, arg_h} : h_room;
        zero_area  = (x9 >= 9'(PIXEL_WIDTH)) || (y9 >= 9'(PIXEL_HEIGHT)) ||
                     (w_eff == 9'd0) || (h_eff == 9'd0);
        clip_bytes = zero_area ? 16'd0 : 16'(w_eff) * 16'(h_eff) * 16'(BYTES_PER_PIXEL);
    end

    // An inflight read already owns a FIFO slot, so it counts against the depth.
    always_comb begin
        occ       = 3'(fifo_count) + 3'(inflight);
        issue     = (state == S_READ) && enable && (occ < 3'(READRECT_FIFO_DEPTH));
        hdr_issue = issue && (hdr_left != 2'd0);
        rd_issue  = issue && (hdr_left == 2'd0);
        abort     = !enable && (state inside {S_ARGS, S_CLIP, S_READ, S_DRAIN});
        push      = inflight && !abort;
        push_data = inflight_hdr ? hdr_byte : ram_data_in;
        drained   = (occ - 3'(tx_valid && tx_ready)) == 3'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (enable) state_nx = S_ARGS;
            S_ARGS:  if (!enable) state_nx = S_IDLE;
                     else if (arg_idx == 2'(READRECT_NUM_ARGS - 1)) state_nx = S_CLIP;
            S_CLIP:  if (!enable) state_nx = S_IDLE;
                     else if (HDR == 0 && zero_area) state_nx = S_DONE;
                     else state_nx = S_READ;
            S_READ:  if (!enable) state_nx = S_IDLE;
                     else if (issue && items_left == 17'd1) state_nx = S_DRAIN;
            S_DRAIN: if (!enable) state_nx = S_IDLE;
                     else if (drained) state_nx = S_DONE;
            S_DONE:  if (!enable) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ready_for_data   = (state == S_ARGS);
        done             = (state == S_DONE);
        ram_read_enable  = rd_issue;
        ram_access_start = rd_issue && first_rd;
        row              = rd_issue ? row_cnt : '0;
        column           = rd_issue ? col_cnt : '0;
        pixel            = rd_issue ? pix_cnt : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arg_idx      <= '0;
            arg_x        <= '0;
            arg_y        <= '0;
            arg_w        <= '0;
            arg_h        <= '0;
            col_first    <= '0;
            col_last     <= '0;
            col_cnt      <= '0;
            row_cnt      <= '0;
            pix_cnt      <= '0;
            byte_total   <= '0;
            items_left   <= '0;
            hdr_left     <= '0;
            hdr_byte     <= '0;
            first_rd     <= 1'b0;
            inflight     <= 1'b0;
            inflight_hdr <= 1'b0;
        end else begin
            if (state == S_IDLE) arg_idx <= '0;
            if (state == S_ARGS && enable) begin
                case (arg_idx)
                    2'd0:    arg_x <= data_in;
                    2'd1:    arg_y <= data_in;
                    2'd2:    arg_w <= data_in;
                    default: arg_h <= data_in;
                endcase
                arg_idx <= arg_idx + 2'd1;
            end
            if (state == S_CLIP) begin
                col_first  <= COL_W'(x9);
                col_cnt    <= COL_W'(x9);
                col_last   <= COL_W'(x9 + w_eff - 9'd1);
                row_cnt    <= ROW_W'(y9);
                pix_cnt    <= '0;
                byte_total <= clip_bytes;
                items_left <= 17'(clip_bytes) + 17'(HDR);
                hdr_left   <= 2'(HDR);
                first_rd   <= 1'b1;
            end
            if (issue) items_left <= items_left - 17'd1;
            if (hdr_issue) begin
                hdr_byte <= (hdr_left == 2'd2) ? byte_total[15:8] : byte_total[7:0];
                hdr_left <= hdr_left - 2'd1;
            end
            // Row-major walk: byte lane fastest, then column, then row.
            if (rd_issue) begin
                first_rd <= 1'b0;
                if (pix_cnt == PIX_W'(BYTES_PER_PIXEL - 1)) begin
                    pix_cnt <= '0;
                    if (col_cnt == col_last) begin
                        col_cnt <= col_first;
                        row_cnt <= row_cnt + ROW_W'(1);
                    end else begin
                        col_cnt <= col_cnt + COL_W'(1);
                    end
                end else begin
                    pix_cnt <= pix_cnt + PIX_W'(1);
                end
            end
            inflight     <= issue && !abort;
            inflight_hdr <= hdr_issue && !abort;
        end
    end

    readrect_skid_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort),
        .push      (push),
        .push_data (push_data),
        .pop       (tx_ready),
        .head      (tx_data),
        .valid     (tx_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_control_cmd_readrect.sv
// Bench for control_cmd_readrect on a 4x4 panel, 2 bytes/pixel; RAM byte = {row,column,pixel}.
module tb_control_cmd_readrect;

`ifdef READRECT_HEADER_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif

    logic       clk, reset, enable, ready_for_data;
    logic [7:0] data_in, ram_data_in, tx_data;
    logic [1:0] row, column;
    logic [0:0] pixel;
    logic       ram_read_enable, ram_access_start, tx_valid, tx_ready, done;

    control_cmd_readrect #(.BYTES_PER_PIXEL(2), .PIXEL_HEIGHT(4), .PIXEL_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
        .ready_for_data(ready_for_data), .row(row), .column(column), .pixel(pixel),
        .ram_read_enable(ram_read_enable), .ram_access_start(ram_access_start),
        .ram_data_in(ram_data_in), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) ram_data_in <= 8'h00;
        else if (ram_read_enable) ram_data_in <= {3'b000, row, column, pixel};
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // tx_ready pattern: 0 = always high, 1 = toggle, 2 = random
    int tx_mode = 0;
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (tx_mode)
                1:       tx_ready = ~tx_ready;
                2:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b1;
            endcase
        end
    end

    // Monitor: per-command traffic, cleared on each rising enable.
    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];
    int n_start = 0, max_out = 0, stab_err = 0;
    initial begin
        logic en_q, prev_stall;
        logic [7:0] prev_data;
        int pt;
        en_q = 1'b0;
        prev_stall = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(posedge clk);
            if (!reset) begin
                prev_stall = 1'b0;
                en_q = 1'b0;
            end else begin
                if (enable && !en_q) begin
                    rd_q.delete();
                    tx_q.delete();
                    n_start = 0;
                    max_out = 0;
                    stab_err = 0;
                end
                en_q = enable;
                if (prev_stall && (!tx_valid || tx_data != prev_data)) stab_err++;
                if (ram_read_enable) begin
                    rd_q.push_back({3'b000, row, column, pixel});
                    if (ram_access_start) n_start++;
                end
                if (tx_valid && tx_ready) tx_q.push_back(tx_data);
                pt = tx_q.size() - HDR;
                if (pt < 0) pt = 0;
                if (rd_q.size() - pt > max_out) max_out = rd_q.size() - pt;
                prev_stall = tx_valid && !tx_ready && enable;
                prev_data = tx_data;
            end
        end
    end

    // Reference model: the bytes a rectangle should produce, from the clipping rules.
    int m_tx[$];
    int m_rd[$];
    task automatic build_model(input int x, input int y, input int w, input int h);
        int we, he, n;
        m_tx.delete();
        m_rd.delete();
        we = 0;
        he = 0;
        if (x < 4 && y < 4) begin
            we = (w < 4 - x) ? w : 4 - x;
            he = (h < 4 - y) ? h : 4 - y;
        end
        n = we * he * 2;
        if (HDR == 2) begin
            m_tx.push_back(n / 256);
            m_tx.push_back(n % 256);
        end
        for (int r = y; r < y + he; r++)
            for (int c = x; c < x + we; c++)
                for (int p = 0; p < 2; p++) begin
                    m_rd.push_back(r * 8 + c * 2 + p);
                    m_tx.push_back(r * 8 + c * 2 + p);
                end
    endtask

    task automatic feed_args(input int x, input int y, input int w, input int h);
        int a[4];
        int k;
        a = '{x, y, w, h};
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'(a[i]);
            k = 0;
            while (!ready_for_data && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (k >= 20) chk("args_ready_timeout", 0, 1);
            @(negedge clk);
        end
    endtask

    typedef struct {
        int x, y, w, h, mode;
        int exp_len;    // pixel bytes only
        int exp_first;  // first pixel byte, -1 when none
    } vec_t;

    task automatic do_cmd(input vec_t v, input string tag);
        int lat, n, rd_bad, tx_bad;
        tx_mode = v.mode;
        build_model(v.x, v.y, v.w, v.h);
        feed_args(v.x, v.y, v.w, v.h);
        lat = 0;
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " done_reached"}, int'(done), 1);
        if (v.exp_len >= 0) begin
            chk({tag, " pixel_len"}, tx_q.size() - HDR, v.exp_len);
            if (v.exp_first >= 0 && tx_q.size() > HDR)
                chk({tag, " first_pixel"}, int'(tx_q[HDR]), v.exp_first);
            if (HDR == 0 && v.exp_len == 0) chk({tag, " zero_done_lat_le3"}, int'(lat <= 3), 1);
        end
        chk({tag, " tx_len"}, tx_q.size(), m_tx.size());
        n = (tx_q.size() < m_tx.size()) ? tx_q.size() : m_tx.size();
        tx_bad = 0;
        for (int i = 0; i < n; i++) if (int'(tx_q[i]) != m_tx[i]) tx_bad++;
        chk({tag, " tx_bytes_wrong"}, tx_bad, 0);
        chk({tag, " read_count"}, rd_q.size(), m_rd.size());
        n = (rd_q.size() < m_rd.size()) ? rd_q.size() : m_rd.size();
        rd_bad = 0;
        for (int i = 0; i < n; i++) if (int'(rd_q[i]) != m_rd[i]) rd_bad++;
        chk({tag, " read_addr_wrong"}, rd_bad, 0);
        chk({tag, " access_start_cnt"}, n_start, (m_rd.size() > 0) ? 1 : 0);
        chk({tag, " max_outstanding_le2"}, int'(max_out <= 2), 1);
        chk({tag, " tx_stable_err"}, stab_err, 0);
        enable = 1'b0;
        @(negedge clk);
        chk({tag, " done_clears"}, int'(done), 0);
    endtask

    function automatic int outs_or();
        return int'(|{ready_for_data, row, column, pixel, ram_read_enable,
                      ram_access_start, tx_data, tx_valid, done});
    endfunction

    vec_t tbl[7];
    vec_t rv;
    int k;

    initial begin
        tbl[0] = '{1, 1, 2, 2, 0, 8, 'h0A};
        tbl[1] = '{1, 1, 2, 2, 1, 8, 'h0A};
        tbl[2] = '{3, 3, 4, 4, 0, 2, 'h1E};
        tbl[3] = '{0, 0, 0, 2, 0, 0, -1};
        tbl[4] = '{2, 0, 9, 1, 2, 4, 'h04};
        tbl[5] = '{4, 0, 1, 1, 0, 0, -1};
        tbl[6] = '{0, 3, 1, 5, 1, 2, 'h18};

        reset = 1'b0;
        enable = 1'b0;
        data_in = 8'h00;
        #1;
        chk("reset_outputs_zero", outs_or(), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) do_cmd(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of streaming.
        tx_mode = 0;
        feed_args(1, 1, 2, 2);
        k = 0;
        while (tx_q.size() < 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid reached_3_bytes", int'(tx_q.size() >= 3), 1);
        #2;
        reset = 1'b0;
        enable = 1'b0;
        #1;
        chk("rst_mid outputs_zero", outs_or(), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_cmd(tbl[0], "after_reset");

        // Abort: drop enable mid-stream, everything must go quiet.
        tx_mode = 1;
        feed_args(0, 0, 4, 4);
        k = 0;
        while (tx_q.size() < 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        @(negedge clk);
        chk("abort tx_valid", int'(tx_valid), 0);
        chk("abort done", int'(done), 0);
        chk("abort read_enable", int'(ram_read_enable), 0);
        @(negedge clk);
        do_cmd(tbl[1], "after_abort");

        for (int i = 0; i < 25; i++) begin
            rv.x = $urandom_range(0, 5);
            rv.y = $urandom_range(0, 5);
            rv.w = $urandom_range(0, 5);
            rv.h = $urandom_range(0, 5);
            rv.mode = $urandom_range(0, 2);
            rv.exp_len = -1;
            rv.exp_first = -1;
            do_cmd(rv, $sformatf("rand%0d(%0d,%0d,%0d,%0d)", i, rv.x, rv.y, rv.w, rv.h));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
